// File: rtl/narrow_pkg.sv
// Shared types and constants for the 32->16 saturating narrower.
// Buffer state encoding and 16-bit saturation limits.
package narrow_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  localparam logic [15:0] SMAX16 = 16'h7FFF;
  localparam logic [15:0] SMIN16 = 16'h8000;
  localparam logic [15:0] UMAX16 = 16'hFFFF;

endpackage

// File: rtl/sat_narrow_comb.sv
// Combinational narrowing of IN_W to OUT_W with saturation.
// Ports: in_data, in_signed -> data (narrowed), ovf (saturated).
module sat_narrow_comb #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  output logic [OUT_W-1:0] data,
  output logic             ovf
);

  localparam logic [OUT_W-1:0] SMAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN =
    {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UMAX =
    {OUT_W{1'b1}};

  logic [IN_W-OUT_W:0] s_top;
  logic                s_ok;
  logic                u_ok;

  // signed fits when the sign bit of the
  // result equals every discarded bit
  assign s_top = in_data[IN_W-1:OUT_W-1];
  assign s_ok  = (&s_top) | ~(|s_top);
  assign u_ok  = ~(|in_data[IN_W-1:OUT_W]);

  always_comb begin
    data = in_data[OUT_W-1:0];
    ovf  = 1'b0;
    unique case (1'b1)
      in_signed && !s_ok: begin
        ovf  = 1'b1;
        data = in_data[IN_W-1] ? SMIN : SMAX;
      end
      !in_signed && !u_ok: begin
        ovf  = 1'b1;
        data = UMAX;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/narrow_sat.sv
// Saturating narrower with 2-entry output buffer and sat counter.
// Ports: in_* handshake in, out_* handshake out, clr_cnt/sat_cnt.
module narrow_sat
  import narrow_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_cnt
);

  logic [OUT_W-1:0] n_data;
  logic             n_ovf;

  sat_narrow_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_narrow (
    .in_data   (in_data),
    .in_signed (in_signed),
    .data      (n_data),
    .ovf       (n_ovf)
  );

  buf_state_e       state_q, state_d;
  logic [OUT_W-1:0] d0_q, d0_d;
  logic [OUT_W-1:0] d1_q, d1_d;
  logic             o0_q, o0_d;
  logic             o1_q, o1_d;
  logic [CNT_W-1:0] cnt_q;
  logic             acc;
  logic             del;

  // ready/valid decode only registered state
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = d0_q;
  assign out_ovf   = o0_q;
  assign sat_cnt   = cnt_q;

  assign acc = in_valid & in_ready;
  assign del = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    o0_d    = o0_q;
    o1_d    = o1_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          d0_d    = n_data;
          o0_d    = n_ovf;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          acc && del: begin
            d0_d = n_data;
            o0_d = n_ovf;
          end
          acc && !del: begin
            d1_d    = n_data;
            o1_d    = n_ovf;
            state_d = TWO;
          end
          !acc && del: state_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (del) begin
          d0_d    = d1_q;
          o0_d    = o1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      d0_q    <= '0;
      d1_q    <= '0;
      o0_q    <= 1'b0;
      o1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      o0_q    <= o0_d;
      o1_q    <= o1_d;
    end
  end

  // clear beats increment; count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (del && o0_q && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_narrow_sat.sv
// Directed self-checking bench for narrow_sat.
// Second instance with a 2-bit counter exercises counter saturation.
module tb_narrow_sat;
  import narrow_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        clr_cnt;
  logic [15:0] sat_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [15:0] out_data2;
  logic        out_ovf2;
  logic [1:0]  sat_cnt2;

  int checks = 0;
  int errors = 0;

  narrow_sat dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .clr_cnt   (clr_cnt),
    .sat_cnt   (sat_cnt)
  );

  narrow_sat #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .out_ovf   (out_ovf2),
    .clr_cnt   (clr_cnt),
    .sat_cnt   (sat_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // one word through an empty buffer, latency 1
  task automatic xfer(input string tag,
                      input logic [31:0] d,
                      input logic s,
                      input logic [15:0] ed,
                      input logic eo);
    @(negedge clk);
    chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_gone"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    xfer("s_fc57", 32'hFFFFFC57, 1'b1, 16'hFC57, 1'b0);
    xfer("u_fc57", 32'h0000FC57, 1'b0, 16'hFC57, 1'b0);
    xfer("s_pos_ovf", 32'h0000FC57, 1'b1, SMAX16, 1'b1);
    xfer("s_12345", 32'h00012345, 1'b1, SMAX16, 1'b1);
    xfer("s_min", 32'h80000000, 1'b1, SMIN16, 1'b1);
    xfer("s_8000", 32'hFFFF8000, 1'b1, 16'h8000, 1'b0);
    xfer("u_10000", 32'h00010000, 1'b0, UMAX16, 1'b1);
    xfer("u_ffff", 32'h0000FFFF, 1'b0, 16'hFFFF, 1'b0);
    chk("cnt_after_vec", 32'(sat_cnt), 32'd4);
    chk("cnt2_saturated", 32'(sat_cnt2), 32'd3);

    // backpressure: A, B buffered, C held
    @(negedge clk);
    clr_cnt   = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("bp_clr", 32'(sat_cnt), 32'd0);
    in_valid  = 1'b1;
    in_data   = 32'h00000001;
    in_signed = 1'b1;
    @(negedge clk);
    chk("bp_rdy_b", 32'(in_ready), 32'd1);
    chk("bp_head_a", 32'(out_data), 32'h0001);
    in_data   = 32'h00020000;
    in_signed = 1'b0;
    @(negedge clk);
    chk("bp_rdy_c", 32'(in_ready), 32'd0);
    in_data   = 32'hFFFFFFFE;
    in_signed = 1'b1;
    @(negedge clk);
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_a", 32'(out_data), 32'h0001);
    chk("bp_hold_ovf", 32'(out_ovf), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_b", 32'(out_data), 32'hFFFF);
    chk("bp_ovf_b", 32'(out_ovf), 32'd1);
    chk("bp_rdy_again", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_vld_c", 32'(out_valid), 32'd1);
    chk("bp_out_c", 32'(out_data), 32'hFFFE);
    chk("bp_ovf_c", 32'(out_ovf), 32'd0);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(sat_cnt), 32'd1);

    // streaming, 1 word per cycle
    in_signed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        chk("st_vld", 32'(out_valid), 32'd1);
        chk("st_rdy", 32'(in_ready), 32'd1);
        chk("st_data", 32'(out_data), 32'((i - 1) * 16 + 3));
      end
      in_valid = 1'b1;
      in_data  = 32'(i * 16 + 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("st_last", 32'(out_data), 32'(7 * 16 + 3));
    @(negedge clk);
    chk("st_drained", 32'(out_valid), 32'd0);

    // counter: three ovf beats, then clear vs increment
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_data   = 32'h40000000;
      in_signed = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("cnt_three", 32'(sat_cnt), 32'd3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    chk("clr_head_ovf", 32'(out_ovf), 32'd1);
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_wins", 32'(sat_cnt), 32'd0);
    chk("clr_drained", 32'(out_valid), 32'd0);

    // reset with two entries buffered
    xfer("pre_rst", 32'hFFFF0000, 1'b1, SMIN16, 1'b1);
    chk("pre_rst_cnt", 32'(sat_cnt), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00000005;
    @(negedge clk);
    in_data = 32'h00000006;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(sat_cnt), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    #1;
    rst_n = 1'b1;
    xfer("post_rst", 32'h00000007, 1'b1, 16'h0007, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
